execute_writeback_unit: RTL and testbench

//  Execute stage fed by the 64x16 register file read ports (ReadDataA/ReadDataB as OperandA/OperandB).

---
 rtl/exec_pkg.sv | 39 +++
 rtl/execute_writeback_unit_if.sv | 36 +++
 rtl/mul_shift_add.sv | 61 ++++++
 rtl/execute_writeback_unit.sv | 157 +++++++++++++++
 tb/tb_execute_writeback_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exec_pkg
// Brief   : Shared types and constants for the execute/writeback unit.
// Revision: 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int MUL_CYCLES         = DEFAULT_DATA_WIDTH;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_MUL  = 4'd7,
        OP_MOVB = 4'd8
    } opcode_t;

    // Every encoding from here upward is a no-operation.
    localparam logic [3:0] OP_NOP_FIRST = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic is_nop(input logic [3:0] op);
        return op >= OP_NOP_FIRST;
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : execute_writeback_unit_if
// Brief   : Operation handshake plus register-file write port bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface execute_writeback_unit_if #(
    parameter int DATA_WIDTH = exec_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = exec_pkg::DEFAULT_ADDR_WIDTH
) ();

    logic                  InValid;
    logic                  InReady;
    logic [3:0]            Opcode;
    logic [ADDR_WIDTH-1:0] DestAddr;
    logic [DATA_WIDTH-1:0] OperandA;
    logic [DATA_WIDTH-1:0] OperandB;
    logic                  WriteEnable;
    logic [ADDR_WIDTH-1:0] WriteAddress;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  WbActive;
    logic                  ZeroFlag;
    logic                  CarryFlag;

    modport master (
        output InValid, Opcode, DestAddr, OperandA, OperandB,
        input  InReady, WriteEnable, WriteAddress, WriteData, WbActive, ZeroFlag, CarryFlag
    );

    modport slave (
        input  InValid, Opcode, DestAddr, OperandA, OperandB,
        output InReady, WriteEnable, WriteAddress, WriteData, WbActive, ZeroFlag, CarryFlag
    );

endinterface
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module  : mul_shift_add
// Brief   : Iterative shift-add multiplier, one multiplier bit per cycle,
//           low DATA_WIDTH bits of the product.
// Revision: 1.0 - initial release
// ============================================================================
module mul_shift_add #(
    parameter int DATA_WIDTH = 16
) (
    input  wire logic                  Clock,
    input  wire logic                  ResetN,
    input  wire logic                  Start,
    input  wire logic [DATA_WIDTH-1:0] A,
    input  wire logic [DATA_WIDTH-1:0] B,
    output logic                       Done,
    output logic [DATA_WIDTH-1:0]      Product
);

    localparam int ITER_W = $clog2(DATA_WIDTH);
    localparam logic [ITER_W-1:0] c_lastIter = ITER_W'(DATA_WIDTH - 1);

    logic                  r_busy;
    logic [ITER_W-1:0]     r_iter;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] w_accNext;

    assign w_accNext = r_acc + (r_b[0] ? r_a : '0);

    // Product is the accumulator after the final step, valid while Done is high.
    assign Done    = r_busy && (r_iter == c_lastIter);
    assign Product = w_accNext;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_busy <= 1'b0;
            r_iter <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (Start) begin
            r_busy <= 1'b1;
            r_iter <= '0;
            r_a    <= A;
            r_b    <= B;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_acc  <= w_accNext;
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_iter <= r_iter + 1'b1;
            if (Done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/execute_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : execute_writeback_unit
// Brief   : Execute stage: single-cycle ALU or shift-add multiply, result
//           delivered on the register-file write port one cycle later.
// Revision: 1.0 - initial release
// ============================================================================
module execute_writeback_unit
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  wire logic               Clock,
    input  wire logic               ResetN,
    execute_writeback_unit_if.slave Bus
);

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_alive;
    logic                  w_accept;
    logic                  w_aluLoad;
    logic                  w_mulStart;
    logic                  w_mulLoad;
    logic                  w_mulDone;
    logic [DATA_WIDTH-1:0] w_mulProduct;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_aluResult;
    logic                  w_aluCarry;
    logic [ADDR_WIDTH-1:0] r_mulDest;
    logic [ADDR_WIDTH-1:0] r_wbAddr;
    logic [DATA_WIDTH-1:0] r_wbData;
    logic                  r_zeroNext;
    logic                  r_carryNext;
    logic                  r_zero;
    logic                  r_carry;

    // r_alive keeps InReady low while reset is held and releases it one edge later.
    assign Bus.InReady      = r_alive && (r_state == IDLE);
    assign w_accept         = Bus.InValid && Bus.InReady;
    assign Bus.WriteEnable  = (r_state == WB);
    assign Bus.WbActive     = (r_state == WB);
    assign Bus.WriteAddress = r_wbAddr;
    assign Bus.WriteData    = r_wbData;
    assign Bus.ZeroFlag     = r_zero;
    assign Bus.CarryFlag    = r_carry;

    assign w_sum = {1'b0, Bus.OperandA} + {1'b0, Bus.OperandB};

    always_comb begin
        w_aluResult = '0;
        w_aluCarry  = 1'b0;
        case (Bus.Opcode)
            OP_ADD: begin
                w_aluResult = w_sum[DATA_WIDTH-1:0];
                w_aluCarry  = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                w_aluResult = Bus.OperandA - Bus.OperandB;
                w_aluCarry  = Bus.OperandA < Bus.OperandB;
            end
            OP_AND:  w_aluResult = Bus.OperandA & Bus.OperandB;
            OP_OR:   w_aluResult = Bus.OperandA | Bus.OperandB;
            OP_XOR:  w_aluResult = Bus.OperandA ^ Bus.OperandB;
            OP_SHL:  w_aluResult = Bus.OperandA << Bus.OperandB[3:0];
            OP_SHR:  w_aluResult = Bus.OperandA >> Bus.OperandB[3:0];
            OP_MOVB: w_aluResult = Bus.OperandB;
            default: w_aluResult = '0;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_aluLoad   = 1'b0;
        w_mulStart  = 1'b0;
        w_mulLoad   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && !is_nop(Bus.Opcode)) begin
                    if (Bus.Opcode == OP_MUL) begin
                        w_mulStart  = 1'b1;
                        w_nextState = MUL;
                    end else begin
                        w_aluLoad   = 1'b1;
                        w_nextState = WB;
                    end
                end
            end
            MUL: begin
                if (w_mulDone) begin
                    w_mulLoad   = 1'b1;
                    w_nextState = WB;
                end
            end
            WB:      w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_alive <= 1'b1;
        end
    end

    // The write port only changes on entry to WB, so it holds steady otherwise.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_mulDest   <= '0;
            r_wbAddr    <= '0;
            r_wbData    <= '0;
            r_zeroNext  <= 1'b0;
            r_carryNext <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            if (w_aluLoad) begin
                r_wbAddr    <= Bus.DestAddr;
                r_wbData    <= w_aluResult;
                r_zeroNext  <= (w_aluResult == '0);
                r_carryNext <= w_aluCarry;
            end
            if (w_mulStart) begin
                r_mulDest <= Bus.DestAddr;
            end
            if (w_mulLoad) begin
                r_wbAddr    <= r_mulDest;
                r_wbData    <= w_mulProduct;
                r_zeroNext  <= (w_mulProduct == '0);
                r_carryNext <= 1'b0;
            end
            if (r_state == WB) begin
                r_zero  <= r_zeroNext;
                r_carry <= r_carryNext;
            end
        end
    end

    mul_shift_add #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .Start   (w_mulStart),
        .A       (Bus.OperandA),
        .B       (Bus.OperandB),
        .Done    (w_mulDone),
        .Product (w_mulProduct)
    );

endmodule
`default_nettype wire

// File: tb/tb_execute_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_execute_writeback_unit
// Brief   : Self-checking bench for execute_writeback_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_execute_writeback_unit;
    import exec_pkg::*;

    logic Clock = 1'b0;
    logic ResetN;
    always #5 Clock = ~Clock;

    execute_writeback_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

    execute_writeback_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .Bus    (bus)
    );

    int nChecks = 0;
    int nFails  = 0;
    int nWrites = 0;
    bit checkEn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode table.
    function automatic void ref_op(input int op, input longint a, input longint b,
                                   output logic [15:0] res, output bit c);
        longint r;
        c = 1'b0;
        case (op)
            0: begin r = a + b; c = ((r >> 16) & 1) != 0; end
            1: begin r = a - b; c = a < b; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << (b & 15);
            6: r = a >> (b & 15);
            7: r = a * b;
            default: r = b;
        endcase
        r   = r & 64'hFFFF;
        res = r[15:0];
    endfunction

    // Behavioural model: expected outputs for the cycle following each edge.
    bit          expReady = 0, expWE = 0, expZ = 0, expC = 0, pendZ = 0, pendC = 0;
    logic [5:0]  expAddr = '0, m_mulDest = '0;
    logic [15:0] expData = '0, m_mulRes = '0, m_res;
    int          m_mulLeft = 0;
    bit          m_took, m_c;

    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            expReady = 0; expWE = 0; expAddr = '0; expData = '0;
            expZ = 0; expC = 0; m_mulLeft = 0;
        end else begin
            m_took = expReady && (bus.InValid === 1'b1);
            if (expWE) begin
                expZ = pendZ;
                expC = pendC;
            end
            expWE = 0;
            if (m_mulLeft > 0) begin
                m_mulLeft--;
                if (m_mulLeft == 0) begin
                    expWE = 1; expAddr = m_mulDest; expData = m_mulRes;
                    pendZ = (m_mulRes == 0); pendC = 0;
                end
            end
            if (m_took && int'(bus.Opcode) <= 8) begin
                ref_op(int'(bus.Opcode), longint'(bus.OperandA), longint'(bus.OperandB), m_res, m_c);
                if (int'(bus.Opcode) == 7) begin
                    m_mulLeft = MUL_CYCLES;
                    m_mulDest = bus.DestAddr;
                    m_mulRes  = m_res;
                end else begin
                    expWE = 1; expAddr = bus.DestAddr; expData = m_res;
                    pendZ = (m_res == 0); pendC = m_c;
                end
            end
            expReady = !expWE && (m_mulLeft == 0);
        end
    end

    always @(posedge Clock) begin
        #2;
        if (checkEn) begin
            chk("InReady",      {31'b0, bus.InReady},     {31'b0, expReady});
            chk("WriteEnable",  {31'b0, bus.WriteEnable}, {31'b0, expWE});
            chk("WbActive",     {31'b0, bus.WbActive},    {31'b0, expWE});
            chk("WriteAddress", {26'b0, bus.WriteAddress}, {26'b0, expAddr});
            chk("WriteData",    {16'b0, bus.WriteData},   {16'b0, expData});
            chk("ZeroFlag",     {31'b0, bus.ZeroFlag},    {31'b0, expZ});
            chk("CarryFlag",    {31'b0, bus.CarryFlag},   {31'b0, expC});
            if (bus.WriteEnable === 1'b1) nWrites++;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] d, output longint t);
        int n;
        @(negedge Clock);
        bus.InValid = 1'b1; bus.Opcode = op; bus.OperandA = a; bus.OperandB = b; bus.DestAddr = d;
        n = 0;
        while (bus.InReady !== 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        chk("accept_wait_bounded", {31'b0, n < 40}, 32'd1);
        @(posedge Clock);
        t = $time;
    endtask

    task automatic directed(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [5:0] d, input logic [15:0] expData_i, input int expLat,
                            input bit expZ_i, input bit expC_i);
        longint t;
        int lat;
        issue(op, a, b, d, t);
        #1;
        bus.InValid = 1'b0; bus.OperandA = 16'($urandom); bus.OperandB = 16'($urandom);
        bus.DestAddr = 6'($urandom); bus.Opcode = 4'($urandom);
        lat = 0;
        while (bus.WriteEnable !== 1'b1 && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
        chk("dir_latency",     lat, expLat);
        chk("dir_ready_in_wb", {31'b0, bus.InReady}, 32'd0);
        chk("dir_addr",        {26'b0, bus.WriteAddress}, {26'b0, d});
        chk("dir_data",        {16'b0, bus.WriteData}, {16'b0, expData_i});
        @(posedge Clock); #1;
        chk("dir_single_pulse", {31'b0, bus.WriteEnable}, 32'd0);
        chk("dir_zero",         {31'b0, bus.ZeroFlag}, {31'b0, expZ_i});
        chk("dir_carry",        {31'b0, bus.CarryFlag}, {31'b0, expC_i});
        chk("dir_ready_after",  {31'b0, bus.InReady}, 32'd1);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_InReady"},     {31'b0, bus.InReady}, 32'd0);
        chk({tag, "_WriteEnable"}, {31'b0, bus.WriteEnable}, 32'd0);
        chk({tag, "_WbActive"},    {31'b0, bus.WbActive}, 32'd0);
        chk({tag, "_WriteAddress"}, {26'b0, bus.WriteAddress}, 32'd0);
        chk({tag, "_WriteData"},   {16'b0, bus.WriteData}, 32'd0);
        chk({tag, "_ZeroFlag"},    {31'b0, bus.ZeroFlag}, 32'd0);
        chk({tag, "_CarryFlag"},   {31'b0, bus.CarryFlag}, 32'd0);
    endtask

    function automatic logic [15:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'($urandom_range(0, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t, t1, t2, t3;
        int w0;
        ResetN = 1'b1;
        bus.InValid = 1'b0; bus.Opcode = '0; bus.DestAddr = '0;
        bus.OperandA = '0; bus.OperandB = '0;
        #1 ResetN = 1'b0;
        checkEn = 1'b1;
        #1 chk_all_reset("rst");
        repeat (2) @(negedge Clock);
        #1 ResetN = 1'b1;
        @(posedge Clock); #1;
        chk("rst_release_ready", {31'b0, bus.InReady}, 32'd1);

        directed(4'd0, 16'hFFFF, 16'h0001, 6'd5,  16'h0000, 0,  1'b1, 1'b1);

        issue(4'd12, 16'h0003, 16'h0004, 6'd33, t);
        #1 bus.InValid = 1'b0;
        repeat (4) begin
            @(posedge Clock); #1;
            chk("nop_no_write", {31'b0, bus.WriteEnable}, 32'd0);
        end
        chk("nop_zero_kept",  {31'b0, bus.ZeroFlag}, 32'd1);
        chk("nop_carry_kept", {31'b0, bus.CarryFlag}, 32'd1);

        directed(4'd1, 16'h0003, 16'h0005, 6'd63, 16'hFFFE, 0,  1'b0, 1'b1);
        directed(4'd7, 16'h0123, 16'h0010, 6'd2,  16'h1230, 16, 1'b0, 1'b0);
        directed(4'd5, 16'h0001, 16'hFFF4, 6'd7,  16'h0010, 0,  1'b0, 1'b0);
        directed(4'd8, 16'h1234, 16'h0000, 6'd11, 16'h0000, 0,  1'b1, 1'b0);

        w0 = nWrites;
        issue(4'd0, 16'h0001, 16'h0002, 6'd10, t1);
        issue(4'd2, 16'hF0F0, 16'hFF00, 6'd11, t2);
        issue(4'd4, 16'hAAAA, 16'h5555, 6'd12, t3);
        #1 bus.InValid = 1'b0;
        repeat (2) @(posedge Clock);
        #3;
        chk("b2b_gap1",   32'(t2 - t1), 32'd20);
        chk("b2b_gap2",   32'(t3 - t2), 32'd20);
        chk("b2b_writes", nWrites - w0, 32'd3);

        issue(4'd0, 16'h0001, 16'h0001, 6'd9, t);
        #3 ResetN = 1'b0;
        bus.InValid = 1'b0;
        #1 chk_all_reset("rst_in_wb");
        @(negedge Clock); #1 ResetN = 1'b1;
        @(posedge Clock); #1;
        chk("rst_in_wb_ready", {31'b0, bus.InReady}, 32'd1);

        directed(4'd3, 16'h00F0, 16'h0F00, 6'd44, 16'h0FF0, 0, 1'b0, 1'b0);

        issue(4'd7, 16'hFFFF, 16'hFFFF, 6'd20, t);
        #1 bus.InValid = 1'b0;
        repeat (5) @(posedge Clock);
        @(negedge Clock); #2 ResetN = 1'b0;
        #1 chk_all_reset("rst_in_mul");
        @(negedge Clock); #1 ResetN = 1'b1;
        w0 = nWrites;
        @(posedge Clock); #1;
        chk("rst_in_mul_ready", {31'b0, bus.InReady}, 32'd1);
        repeat (20) @(posedge Clock);
        #3 chk("rst_in_mul_discarded", nWrites - w0, 32'd0);

        repeat (400) begin
            @(negedge Clock);
            bus.InValid  = ($urandom_range(0, 9) < 7);
            bus.Opcode   = 4'($urandom_range(0, 15));
            bus.DestAddr = 6'($urandom);
            bus.OperandA = rnd_operand();
            bus.OperandB = rnd_operand();
        end
        @(negedge Clock);
        bus.InValid = 1'b0;
        repeat (25) @(posedge Clock);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
